// File: rtl/regbank_seq.sv
// regbank_seq: byte register bank with pair view, stack pointer, program counter and a two-cycle pair exchange.
module regbank_seq #(
  parameter int DATASIZE = 8,
  parameter int REGSBITS = 3,
  parameter logic [2*DATASIZE-1:0] RESETPC = '0
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [2:0]            cmd_op,
  input  logic [REGSBITS-1:0]   cmd_ra,
  input  logic [REGSBITS-2:0]   cmd_rb,
  input  logic [2*DATASIZE-1:0] cmd_d,
  input  logic [REGSBITS-1:0]   rd_a,
  output logic [DATASIZE-1:0]   rd_q,
  input  logic [REGSBITS-2:0]   rp_a,
  output logic [2*DATASIZE-1:0] rp_q,
  input  logic                  pc_inc,
  input  logic                  pc_ld,
  input  logic [2*DATASIZE-1:0] pc_d,
  output logic [2*DATASIZE-1:0] pc_q,
  output logic                  done,
  output logic                  ixz
);
  localparam int REGCOUNT = 2**REGSBITS;
  localparam int PAIRSIZE = 2*DATASIZE;
  localparam int REGPBITS = REGSBITS-1;
  localparam int NPAIRS   = 2**REGPBITS;
  localparam logic [2:0] OP_WRB = 3'b001, OP_WRP = 3'b010, OP_INC = 3'b011,
                         OP_DEC = 3'b100, OP_CPY = 3'b101, OP_XCH = 3'b110;
  typedef enum logic {IDLE, XCH2} state_t;
  state_t r_state, w_next;
  logic [DATASIZE-1:0] r_regs [REGCOUNT];
  logic [PAIRSIZE-1:0] r_sp, r_pc, r_tmp;
  logic [REGPBITS-1:0] r_xrb;
  logic                r_done, r_ixz;
  logic [PAIRSIZE-1:0] w_pairs [NPAIRS];
  logic [REGPBITS-1:0] w_ra, w_pwa;
  logic [PAIRSIZE-1:0] w_pa, w_pb, w_pwd;
  logic                w_acc, w_pwe, w_bwe, w_idc;
  // The all-ones pair index aliases SP, not the top two byte registers
  for (genvar g = 0; g < NPAIRS; g++) begin : g_pair
    if (g == NPAIRS-1) begin : g_sp
      assign w_pairs[g] = r_sp;
    end else begin : g_reg
      assign w_pairs[g] = {r_regs[2*g], r_regs[2*g+1]};
    end
  end
  assign w_ra    = cmd_ra[REGPBITS-1:0];
  assign w_pa    = w_pairs[w_ra];
  assign w_pb    = w_pairs[cmd_rb];
  assign cmd_rdy = r_state == IDLE;
  assign w_acc   = cmd_vld && cmd_rdy;
  assign w_idc   = w_acc && (cmd_op == OP_INC || cmd_op == OP_DEC);
  assign rd_q    = r_regs[rd_a];
  assign rp_q    = w_pairs[rp_a];
  assign pc_q    = r_pc;
  assign done    = r_done;
  assign ixz     = r_ixz;
  always_comb begin
    w_next = r_state;
    w_pwe  = 1'b0;
    w_bwe  = 1'b0;
    w_pwa  = w_ra;
    w_pwd  = cmd_d;
    if (r_state == XCH2) begin
      w_next = IDLE;
      w_pwe  = 1'b1;
      w_pwa  = r_xrb;
      w_pwd  = r_tmp;
    end else if (cmd_vld) begin
      case (cmd_op)
        OP_WRB: w_bwe = 1'b1;
        OP_WRP: w_pwe = 1'b1;
        OP_INC: begin w_pwe = 1'b1; w_pwd = w_pa + 1'b1; end
        OP_DEC: begin w_pwe = 1'b1; w_pwd = w_pa - 1'b1; end
        OP_CPY: begin w_pwe = 1'b1; w_pwd = w_pb; end
        OP_XCH: begin w_pwe = 1'b1; w_pwd = w_pb; w_next = XCH2; end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst_)
    if (rst_) r_state <= IDLE;
    else      r_state <= w_next;
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int i = 0; i < REGCOUNT; i++) r_regs[i] <= '0;
      r_sp   <= '0;
      r_tmp  <= '0;
      r_xrb  <= '0;
      r_pc   <= RESETPC;
      r_done <= 1'b0;
      r_ixz  <= 1'b0;
    end else begin
      if (w_bwe) r_regs[cmd_ra] <= cmd_d[DATASIZE-1:0];
      if (w_pwe && &w_pwa) r_sp <= w_pwd;
      if (w_pwe && !(&w_pwa)) begin
        r_regs[{w_pwa, 1'b0}] <= w_pwd[PAIRSIZE-1:DATASIZE];
        r_regs[{w_pwa, 1'b1}] <= w_pwd[DATASIZE-1:0];
      end
      if (w_acc && cmd_op == OP_XCH) begin
        r_tmp <= w_pa;
        r_xrb <= cmd_rb;
      end
      if (w_idc) r_ixz <= w_pwd == '0;
      r_done <= (w_acc && cmd_op != OP_XCH) || r_state == XCH2;
      r_pc   <= pc_ld ? pc_d : pc_inc ? r_pc + 1'b1 : r_pc;
    end
  end
endmodule
